// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and sequencing controller for the 5-stage RISC-V core.
//               Owns every Stall/Flush of the F/D, D/E, E/M and M/W pipeline
//               registers, computes E-stage operand forwarding, sequences
//               variable-latency data-memory accesses (req/ready with a
//               timeout), fixed-latency mul/div in E, load-use and branch
//               hazards, and counts stalled fetch cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MulDivE,
    input  logic        MemAccessM,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    // Mul/div cycle counter width; one extra bit so MUL_LAT-1 always fits.
    localparam int            CW        = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] C_MD_LAST = CW'(MUL_LAT - 1);
    localparam logic [7:0]    C_TO_LAST = 8'(MEM_TIMEOUT - 1);

    // Memory access FSM encoding.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [7:0]    r_to_cnt;
    logic          r_timeout;
    logic [CW-1:0] r_md_cnt;
    logic [15:0]   r_stall_cnt;

    logic          w_memstall;
    logic          w_to_release;
    logic          w_mem_req_raw;
    logic          w_mdstall;
    logic          w_lustall;

    // ------------------------------------------------------------------------
    // Memory FSM
    // ------------------------------------------------------------------------

    // State register; reset aborts any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a miss parks in WAIT until ready or the timeout expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (MemAccessM && !mem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready || (r_to_cnt == C_TO_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: memory stall, timeout release and raw request.
    always_comb begin
        w_memstall    = 1'b0;
        w_to_release  = 1'b0;
        w_mem_req_raw = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_req_raw = MemAccessM;
                w_memstall    = MemAccessM && !mem_ready;
            end
            S_WAIT: begin
                w_mem_req_raw = 1'b1;
                if (mem_ready) begin
                    w_memstall = 1'b0;
                end else if (r_to_cnt == C_TO_LAST) begin
                    // Give up: let the instruction go and squash its result.
                    w_to_release = 1'b1;
                end else begin
                    w_memstall = 1'b1;
                end
            end
            default: begin
                w_mem_req_raw = 1'b0;
            end
        endcase
    end

    // Timeout counter: zero on WAIT entry, counts each cycle spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_WAIT)) begin
            r_to_cnt <= 8'd0;
        end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_to_release) begin
            r_timeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Mul/div sequencing and load-use detection
    // ------------------------------------------------------------------------

    assign w_mdstall = MulDivE && (r_md_cnt < C_MD_LAST);
    assign w_lustall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Mul/div cycle counter: frozen under a memory stall, cleared on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= '0;
        end else if (w_mdstall && !w_memstall) begin
            r_md_cnt <= r_md_cnt + CW'(1);
        end else if (!StallM && !w_mdstall) begin
            r_md_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Stall / flush priority: memory, mul/div, branch, load-use
    // ------------------------------------------------------------------------

    // Resolve hazards in priority order; everything is quiet during reset.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        FlushW  = 1'b0;
        mem_req = 1'b0;
        if (!rst) begin
            mem_req = w_mem_req_raw;
            if (w_memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (w_mdstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lustall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            // A timed-out access advances but must not write back.
            if (w_to_release) begin
                FlushW = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding: M has the newer value and wins over W
    // ------------------------------------------------------------------------

    // Select E-stage operand sources from in-flight writers.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------------

    // Saturating count of cycles with the fetch stage held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (StallF && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign mem_timeout = r_timeout;
    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It drives the enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers and computes E-stage operand forwarding. It also sequences three events: variable-latency data-memory accesses through a request/ready handshake, a fixed-latency multi-cycle mul/div unit in E, and load-use and branch hazards. It sits beside the datapath and owns every Stall/Flush signal; the pipeline registers only obey it.

## Interface
- MUL_LAT, 4, cycles a mul/div instruction occupies E (≥1)
- MEM_TIMEOUT, 255, max WAIT cycles before forced release (≥1, fits 8 bits)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Rs1D, Rs2D  in  5  source regs in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs in E
- RdM, RdW  in  5  dest regs in M, W
- RegWriteM, RegWriteW  in  1  write-enables in M, W
- LoadE  in  1  instruction in E is a load (ResultSrcE==01)
- PCSrcE  in  1  branch/jump taken, resolved in E
- MulDivE  in  1  instruction in E is mul/div
- MemAccessM  in  1  load/store in M
- mem_ready  in  1  data memory completes the current access this cycle
- mem_req  out  1  data memory request, held until ready
- StallF, StallD, StallE, StallM  out  1  hold PC / F/D / D/E / E/M (en = ~Stall)
- FlushD, FlushE, FlushM, FlushW  out  1  clear F/D / D/E / E/M / M/W
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- mem_timeout  out  1  sticky timeout error
- stall_count  out  16  saturating count of cycles with StallF=1

## Operation
- Memory FSM, states IDLE/WAIT.
  - IDLE: if MemAccessM && !mem_ready -> WAIT, and memstall=1.
  - IDLE with MemAccessM && mem_ready: zero-wait access, no stall.
  - WAIT: memstall=1 while !mem_ready.
  - WAIT with mem_ready: memstall=0 that cycle, the instruction advances, -> IDLE.
  - mem_req = MemAccessM in IDLE, 1 in WAIT.
- Timeout: an 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the counter reaches MEM_TIMEOUT-1 without mem_ready, the access is treated as done: memstall=0, FlushW=1 (suppresses the bogus result), mem_timeout set, -> IDLE.
  - mem_timeout clears only on rst.
- Mul/div counter (width $clog2(MUL_LAT)+1):
  - mdstall = MulDivE && cnt < MUL_LAT-1.
  - cnt increments when mdstall && !memstall.
  - cnt clears when the D/E→E/M transfer happens (StallM=0 and mdstall=0).
  - MUL_LAT=1 never stalls.
- Load-use: lustall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Priority, first match wins:
  - memstall: StallF=StallD=StallE=StallM=1, FlushW=1; PCSrcE ignored.
  - mdstall: StallF=StallD=StallE=1, FlushM=1; PCSrcE ignored.
  - PCSrcE: FlushD=FlushE=1, no stalls; lustall suppressed.
  - lustall: StallF=StallD=1, FlushE=1.
  - else all 0.
- Forwarding (all combinational, independent of stalls):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE: same, using Rs2E. M beats W.
- stall_count increments when StallF=1, saturates at 16'hFFFF.

## Timing
- Stall/Flush/Forward/mem_req are combinational from inputs and state, with no added latency; registered state updates on posedge clk.
- While rst=1: all Stall*/Flush* 0, mem_req 0, Forward* 00. After the next edge: state IDLE, cnt 0, timeout counter 0, mem_timeout 0, stall_count 0.
- rst during WAIT aborts the access; mem_req drops in the same cycle.
- A miss costs exactly N stall cycles, where mem_ready arrives N cycles after the WAIT entry cycle's edge.
- A mul/div costs MUL_LAT-1 stall cycles when no memory stall is active. A memory stall overlapping a mul/div freezes cnt.
- A load-use hazard costs exactly 1 bubble.
- A taken branch costs 2 flushed slots.
- A branch in E during a memory stall or mul/div stall flushes on the first cycle both stalls are low.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. With RdM=0 instead -> ForwardAE=01. With Rs2E=5 and RegWriteW=0 -> ForwardBE=00.
- Load-use: LoadE=1, RdE=3, Rs2D=3 -> one cycle of StallF=StallD=FlushE=1. Repeat with PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
- Memory miss: MemAccessM=1, mem_ready low 3 cycles then high 1 cycle -> StallF..StallM=FlushW=1 for exactly 3 cycles, mem_req high 4 cycles, stall_count=3.
- Mul/div with MUL_LAT=4: MulDivE=1 held -> 3 stall cycles with FlushM=1, then advance. A memory stall injected mid-sequence extends the sequence by the miss length.
- Timeout with MEM_TIMEOUT=8: mem_ready never asserts -> release after 8 WAIT cycles, FlushW=1 on the release cycle, mem_timeout=1 stays set until rst.
- Reset mid-WAIT, and stall_count saturation: rst during WAIT -> state IDLE, mem_req=0, counters 0. 70000 stalled cycles -> stall_count=FFFF.
